coef_fifo_reader: RTL and testbench



---
 rtl/coef_fifo_pkg.sv | 26 ++
 rtl/coef_frame_parser.sv | 101 ++++++++++
 rtl/coef_fifo_reader.sv | 96 +++++++++
 tb/tb_coef_fifo_reader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_fifo_pkg.sv
// Shared types and constants for the coefficient FIFO reader.
package coef_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CSR_RD,
        ST_CSR_WAIT,
        ST_GAP,
        ST_DATA_RD,
        ST_DATA_WAIT
    } fsm_state_e;

    typedef enum logic {
        PS_HDR,
        PS_COEF
    } parse_state_e;

    localparam int MAGIC_HI = 31;
    localparam int MAGIC_LO = 16;
    localparam int COUNT_HI = 7;
    localparam int COUNT_LO = 0;
    localparam int FILL_W   = 16;

    localparam logic [2:0] CSR_FILL_LEVEL = 3'd0;

endpackage

// File: rtl/coef_frame_parser.sv
// Frame parser: checks headers, tracks index/remaining, and registers the
// coefficient and frame pulses for the filter bank.
module coef_frame_parser
    import coef_fifo_pkg::*;
#(
    parameter int          N_COEF = 64,
    parameter logic [15:0] MAGIC  = 16'hC0EF
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        word_valid,
    input  logic [31:0] word,
    output logic        coef_valid,
    output logic [7:0]  coef_index,
    output logic [31:0] coef_data,
    output logic        frame_done,
    output logic        frame_err
);

    parse_state_e state_q, state_d;
    logic [7:0]   remaining_q, remaining_d;
    logic [7:0]   index_q, index_d;
    logic         coef_valid_q, coef_valid_d;
    logic [7:0]   coef_index_q, coef_index_d;
    logic [31:0]  coef_data_q, coef_data_d;
    logic         frame_done_q, frame_done_d;
    logic         frame_err_q, frame_err_d;

    logic [7:0] hdr_count;
    logic       hdr_ok;

    assign hdr_count = word[COUNT_HI:COUNT_LO];
    assign hdr_ok    = (word[MAGIC_HI:MAGIC_LO] == MAGIC) && (hdr_count != 8'd0)
                       && (int'(hdr_count) <= N_COEF);

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        index_d      = index_q;
        coef_valid_d = 1'b0;
        coef_index_d = coef_index_q;
        coef_data_d  = coef_data_q;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;
        if (word_valid) begin
            case (state_q)
                PS_HDR: begin
                    // A rejected header is dropped; the next word is again a header candidate.
                    if (hdr_ok) begin
                        remaining_d = hdr_count;
                        index_d     = 8'd0;
                        state_d     = PS_COEF;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                PS_COEF: begin
                    coef_valid_d = 1'b1;
                    coef_index_d = index_q;
                    coef_data_d  = word;
                    index_d      = index_q + 8'd1;
                    remaining_d  = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        frame_done_d = 1'b1;
                        state_d      = PS_HDR;
                    end
                end
                default: state_d = PS_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q      <= PS_HDR;
            remaining_q  <= 8'd0;
            index_q      <= 8'd0;
            coef_valid_q <= 1'b0;
            coef_index_q <= 8'd0;
            coef_data_q  <= 32'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            index_q      <= index_d;
            coef_valid_q <= coef_valid_d;
            coef_index_q <= coef_index_d;
            coef_data_q  <= coef_data_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign coef_valid = coef_valid_q;
    assign coef_index = coef_index_q;
    assign coef_data  = coef_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/coef_fifo_reader.sv
// Polls the coefficient FIFO fill level and pops words only while data is
// known to be present; framing is handled by coef_frame_parser.
module coef_fifo_reader
    import coef_fifo_pkg::*;
#(
    parameter int          N_COEF   = 64,
    parameter int          POLL_GAP = 16,
    parameter logic [15:0] MAGIC    = 16'hC0EF
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        run,
    output logic        fifo_read,
    input  logic [31:0] fifo_readdata,
    output logic [2:0]  csr_address,
    output logic        csr_read,
    input  logic [31:0] csr_readdata,
    output logic        coef_valid,
    output logic [7:0]  coef_index,
    output logic [31:0] coef_data,
    output logic        frame_done,
    output logic        frame_err
);

    // GAP plus the following IDLE cycle give POLL_GAP quiet cycles between polls.
    localparam logic [15:0] GAP_LOAD = 16'(POLL_GAP - 2);

    fsm_state_e        state_q, state_d;
    logic [FILL_W-1:0] avail_q, avail_d;
    logic [15:0]       gap_q, gap_d;
    logic              word_valid;
    logic              unused_csr_hi;

    assign unused_csr_hi = ^csr_readdata[31:FILL_W];

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_IDLE;
            avail_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            avail_q <= avail_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        avail_d = avail_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: if (run) state_d = ST_CSR_RD;
            ST_CSR_RD: state_d = ST_CSR_WAIT;
            ST_CSR_WAIT: begin
                avail_d = csr_readdata[FILL_W-1:0];
                gap_d   = GAP_LOAD;
                state_d = (csr_readdata[FILL_W-1:0] == '0) ? ST_GAP : ST_DATA_RD;
            end
            ST_GAP: begin
                if (gap_q == 16'd0) state_d = ST_IDLE;
                else                gap_d   = gap_q - 16'd1;
            end
            ST_DATA_RD: begin
                avail_d = avail_q - 1'b1;
                state_d = ST_DATA_WAIT;
            end
            ST_DATA_WAIT: state_d = (avail_q != '0 && run) ? ST_DATA_RD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        csr_read   = (state_q == ST_CSR_RD);
        fifo_read  = (state_q == ST_DATA_RD);
        word_valid = (state_q == ST_DATA_WAIT);
    end

    assign csr_address = CSR_FILL_LEVEL;

    coef_frame_parser #(
        .N_COEF (N_COEF),
        .MAGIC  (MAGIC)
    ) u_parser (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .word_valid  (word_valid),
        .word        (fifo_readdata),
        .coef_valid  (coef_valid),
        .coef_index  (coef_index),
        .coef_data   (coef_data),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

endmodule

// File: tb/tb_coef_fifo_reader.sv
// Bench for coef_fifo_reader: FIFO/CSR slave model, word-stream frame model
// and event scoreboard, directed table plus randomized frames.
module tb_coef_fifo_reader;

    localparam int N_COEF   = 64;
    localparam int POLL_GAP = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        run = 1'b0;
    logic        fifo_read;
    logic [31:0] fifo_readdata = 32'd0;
    logic [2:0]  csr_address;
    logic        csr_read;
    logic [31:0] csr_readdata = 32'd0;
    logic        coef_valid;
    logic [7:0]  coef_index;
    logic [31:0] coef_data;
    logic        frame_done;
    logic        frame_err;

    coef_fifo_reader #(.N_COEF(N_COEF), .POLL_GAP(POLL_GAP), .MAGIC(16'hC0EF)) dut (
        .clk_clk       (clk_clk),
        .reset_reset   (reset_reset),
        .run           (run),
        .fifo_read     (fifo_read),
        .fifo_readdata (fifo_readdata),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_readdata  (csr_readdata),
        .coef_valid    (coef_valid),
        .coef_index    (coef_index),
        .coef_data     (coef_data),
        .frame_done    (frame_done),
        .frame_err     (frame_err)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // FIFO contents: fq holds pushed words, only the first vis are reported as filled.
    logic [31:0] fq[$];
    int          vis = 0;
    logic [15:0] junk;

    typedef struct {
        bit          is_err;
        int          idx;
        logic [31:0] data;
        bit          done;
        int          cyc;
    } ev_t;
    ev_t exq[$];

    bit m_coef = 0;
    int m_rem = 0;
    int m_idx = 0;
    int n_coef = 0, n_done = 0, n_err = 0, n_csr = 0, n_fifo = 0;
    int csr_cyc[$];

    task automatic model_word(input logic [31:0] w, input int c);
        ev_t e;
        int  cnt;
        cnt = int'(w[7:0]);
        e.is_err = 0; e.idx = 0; e.data = w; e.done = 0; e.cyc = c + 2;
        if (!m_coef) begin
            if (w[31:16] == 16'hC0EF && cnt >= 1 && cnt <= N_COEF) begin
                m_coef = 1; m_rem = cnt; m_idx = 0;
            end else begin
                e.is_err = 1;
                exq.push_back(e);
            end
        end else begin
            e.idx  = m_idx;
            e.done = (m_rem == 1);
            exq.push_back(e);
            m_idx++;
            m_rem--;
            if (m_rem == 0) m_coef = 0;
        end
    endtask

    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (csr_read || fifo_read) check("strobe_exclusive", csr_read & fifo_read, 0);
            if (csr_read) begin
                check("csr_address", csr_address, 0);
                n_csr++;
                csr_cyc.push_back(cyc);
                junk = 16'($urandom);
                csr_readdata = {junk, 16'(vis)};
            end
            if (fifo_read) begin
                n_fifo++;
                check("no_underflow", (vis > 0 && fq.size() > 0), 1);
                if (vis > 0 && fq.size() > 0) begin
                    fifo_readdata = fq.pop_front();
                    vis--;
                    model_word(fifo_readdata, cyc);
                end else begin
                    fifo_readdata = 32'hDEADBEEF;
                end
            end
            if (coef_valid || frame_err || frame_done) begin
                ev_t e;
                n_coef += int'(coef_valid);
                n_done += int'(frame_done);
                n_err  += int'(frame_err);
                check("done_has_valid", frame_done & ~coef_valid, 0);
                check("event_expected", (exq.size() > 0), 1);
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    check("event_kind_err", frame_err, e.is_err);
                    check("event_latency", cyc, e.cyc);
                    if (!e.is_err) begin
                        check("coef_valid", coef_valid, 1);
                        check("coef_index", coef_index, e.idx);
                        check("coef_data", coef_data, e.data);
                        check("frame_done", frame_done, e.done);
                    end
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fq.push_back(w);
    endtask

    task automatic release_words(input int n);
        vis += n;
    endtask

    task automatic wait_drain();
        int quiet = 0;
        bit ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk_clk);
            if (vis == 0 && exq.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 6) begin
                ok = 1;
                break;
            end
        end
        #1;
        check("drain_done", ok, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_fifo_read", fifo_read, 0);
        check("rst_csr_read", csr_read, 0);
        check("rst_csr_address", csr_address, 0);
        check("rst_coef_valid", coef_valid, 0);
        check("rst_coef_index", coef_index, 0);
        check("rst_coef_data", coef_data, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_err", frame_err, 0);
    endtask

    task automatic do_reset(input int n);
        reset_reset = 1'b1;
        cycles(n);
        m_coef = 0; m_rem = 0; m_idx = 0;
        exq.delete();
        check_reset_outputs();
        reset_reset = 1'b0;
    endtask

    typedef struct {
        int          nw;
        logic [31:0] w [8];
        int          e_coef;
        int          e_done;
        int          e_err;
    } vec_t;

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[4];
        int   b_coef, b_done, b_err, b_csr, b_fifo;
        bit   ok;

        vt[0] = '{4, '{32'hC0EF0003, 32'h11, 32'h22, 32'h33, 0, 0, 0, 0}, 3, 1, 0};
        vt[1] = '{5, '{32'h12340002, 32'hC0EF0000, 32'hC0EF0041, 32'hC0EF0001, 32'h55, 0, 0, 0}, 1, 1, 3};
        vt[2] = '{3, '{32'hC0EFFF02, 32'hAAAA0001, 32'h0000BBBB, 0, 0, 0, 0, 0}, 2, 1, 0};
        vt[3] = '{3, '{32'hC0EE0001, 32'hC0EF0001, 32'h99, 0, 0, 0, 0, 0}, 1, 1, 1};

        do_reset(4);
        cycles(10);
        check("idle_without_run", n_csr, 0);

        // Empty FIFO: regular polling, no data reads.
        run = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            if (csr_cyc.size() >= 4) begin ok = 1; break; end
        end
        check("empty_polls_seen", ok, 1);
        if (ok) begin
            for (int i = 1; i < 4; i++) check("poll_interval", csr_cyc[i] - csr_cyc[i-1], POLL_GAP + 2);
        end
        check("empty_no_fifo_read", n_fifo, 0);

        for (int v = 0; v < 4; v++) begin
            b_coef = n_coef; b_done = n_done; b_err = n_err;
            for (int j = 0; j < vt[v].nw; j++) push(vt[v].w[j]);
            release_words(vt[v].nw);
            wait_drain();
            check("tbl_coef_count", n_coef - b_coef, vt[v].e_coef);
            check("tbl_done_count", n_done - b_done, vt[v].e_done);
            check("tbl_err_count", n_err - b_err, vt[v].e_err);
            b_csr = n_csr;
            cycles(40);
            check("tbl_repoll", (n_csr > b_csr), 1);
        end

        // Split delivery across two polls.
        b_coef = n_coef; b_done = n_done;
        push(32'hC0EF0003); push(32'hA0); push(32'hA1); push(32'hA2);
        release_words(2);
        wait_drain();
        check("split_first_coef", n_coef - b_coef, 1);
        check("split_first_done", n_done - b_done, 0);
        release_words(2);
        wait_drain();
        check("split_total_coef", n_coef - b_coef, 3);
        check("split_total_done", n_done - b_done, 1);

        // Largest legal frame.
        b_coef = n_coef; b_done = n_done;
        push(32'hC0EF0040);
        for (int j = 0; j < 64; j++) push($urandom);
        release_words(65);
        wait_drain();
        check("max_coef", n_coef - b_coef, 64);
        check("max_done", n_done - b_done, 1);

        // run dropped mid-frame after the second coefficient.
        b_coef = n_coef; b_done = n_done;
        push(32'hC0EF0005);
        for (int j = 0; j < 5; j++) push(32'h500 + j);
        release_words(6);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cycles(1);
            if (n_coef - b_coef >= 2) begin ok = 1; break; end
        end
        check("run_drop_reached", ok, 1);
        run = 1'b0;
        cycles(4);
        b_csr = n_csr; b_fifo = n_fifo;
        begin
            int c0;
            c0 = n_coef;
            cycles(50);
            check("run_low_csr", n_csr - b_csr, 0);
            check("run_low_fifo", n_fifo - b_fifo, 0);
            check("run_low_coef", n_coef - c0, 0);
        end
        run = 1'b1;
        wait_drain();
        check("run_resume_coef", n_coef - b_coef, 5);
        check("run_resume_done", n_done - b_done, 1);

        // Reset in the middle of a frame.
        b_done = n_done; b_err = n_err;
        push(32'hC0EF0003); push(32'h1); push(32'h2);
        release_words(3);
        wait_drain();
        do_reset(3);
        cycles(5);
        check("abort_no_done", n_done - b_done, 0);
        check("abort_no_err", n_err - b_err, 0);
        b_coef = n_coef; b_done = n_done;
        push(32'hC0EF0001); push(32'h77);
        release_words(2);
        wait_drain();
        check("post_reset_coef", n_coef - b_coef, 1);
        check("post_reset_done", n_done - b_done, 1);

        // Randomized frames with occasional bad headers and ragged fill levels.
        for (int f = 0; f < 30; f++) begin
            int total, released, cnt;
            total = 0;
            if ($urandom_range(0, 4) == 0) begin
                logic [15:0] mg;
                cnt = int'($urandom_range(0, 2));
                mg = 16'($urandom_range(1, 65535));
                if (cnt == 0) push({16'hC0EF ^ mg, 8'($urandom), 8'($urandom_range(1, 64))});
                else if (cnt == 1) push({16'hC0EF, 8'($urandom), 8'h00});
                else push({16'hC0EF, 8'($urandom), 8'($urandom_range(65, 255))});
                total = 1;
            end
            cnt = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, N_COEF)) : int'($urandom_range(1, 8));
            push({16'hC0EF, 8'($urandom), 8'(cnt)});
            for (int j = 0; j < cnt; j++) push($urandom);
            total += cnt + 1;
            released = 0;
            while (released < total) begin
                int n;
                n = int'($urandom_range(1, 6));
                if (n > total - released) n = total - released;
                release_words(n);
                released += n;
                cycles(int'($urandom_range(0, 40)));
            end
            wait_drain();
        end

        check("scoreboard_empty", exq.size(), 0);
        check("fifo_empty", fq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
